rr_requester_agent: RTL and testbench

//  Client-side agent for one port of the 4-way round-robin arbiter.
//  - Buffers words written by local logic in a FIFO.
//  - Raises Request while words remain to send.
//  - Pops exactly one word onto the shared bus per cycle in which its Grant bit is high.
//  - Detects starvation and grants that arrive when it has nothing to send.
//  - Instantiated once per requester; its Request/Grant connect to one bit of the arbiter.

---
 rtl/rr_requester_agent.sv | 165 ++++++++++++++++
 tb/tb_rr_requester_agent.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_requester_agent.sv
`default_nettype none
// ============================================================================
// Module   : rr_requester_agent
// Purpose  : Client-side agent for one port of a 4-way round-robin arbiter.
//            Buffers locally written words in a FIFO, requests the shared bus
//            while words remain, pops one word per granted cycle onto a
//            registered bus, and flags starvation and wasted (empty) grants.
// Revision : 1.0 - initial release
// ============================================================================
module rr_requester_agent #(
  parameter int DATA_W       = 8,
  parameter int DEPTH        = 8,
  parameter int STARVE_LIMIT = 16
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     Request,
  input  logic                     Grant,
  output logic                     bus_valid,
  output logic [DATA_W-1:0]        bus_data,
  output logic                     starve,
  output logic [7:0]               wasted
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;
  localparam int SW    = $clog2(STARVE_LIMIT + 1);

  localparam logic [AW-1:0]    c_ptr_one   = AW'(1);
  localparam logic [CNT_W-1:0] c_cnt_zero  = '0;
  localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_cnt_full  = CNT_W'(DEPTH);
  localparam logic [SW-1:0]    c_st_one    = SW'(1);
  localparam logic [SW-1:0]    c_st_limit  = SW'(STARVE_LIMIT);
  localparam logic [7:0]       c_waste_max = 8'hFF;

  // FIFO storage and pointers
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  // Registered bus side and monitors
  logic              r_bus_valid;
  logic [DATA_W-1:0] r_bus_data;
  logic [SW-1:0]     r_starve_cnt;
  logic              r_starve;
  logic [7:0]        r_wasted;

  // Combinational control
  logic              w_full;
  logic              w_empty;
  logic              w_write;
  logic              w_pop;
  logic              w_request;
  logic              w_empty_grant;
  logic [CNT_W-1:0]  w_count_next;
  logic [SW-1:0]     w_starve_next;

  // FIFO status, handshake qualification and Request generation.
  // Request looks at Grant so it falls in the same cycle the last word pops;
  // Grant is a flop inside the arbiter, so this cannot form a loop.
  always_comb begin
    w_full        = (r_count == c_cnt_full);
    w_empty       = (r_count == c_cnt_zero);
    w_write       = wr_en && !w_full;
    w_pop         = Grant && !w_empty;
    w_empty_grant = Grant && w_empty;
    w_request     = (r_count > c_cnt_one) || ((r_count == c_cnt_one) && !Grant);
  end

  // Occupancy update: a dropped write (while full) never counts, even when a
  // pop frees a slot in the same cycle.
  always_comb begin
    w_count_next = r_count;
    if (w_write && !w_pop) begin
      w_count_next = r_count + c_cnt_one;
    end else if (!w_write && w_pop) begin
      w_count_next = r_count - c_cnt_one;
    end
  end

  // Ungranted-request streak: clears on any Grant or idle Request, saturates.
  always_comb begin
    w_starve_next = r_starve_cnt;
    if (Grant || !w_request) begin
      w_starve_next = '0;
    end else if (r_starve_cnt != c_st_limit) begin
      w_starve_next = r_starve_cnt + c_st_one;
    end
  end

  // FIFO storage write; contents need no reset because pointers define validity.
  always_ff @(posedge Clk) begin
    if (!Reset && w_write) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH (power of 2).
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_write) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
      r_count <= w_count_next;
    end
  end

  // Registered bus: a granted pop presents the head word on the next cycle;
  // otherwise bus_data holds its last value with bus_valid low.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_bus_valid <= 1'b0;
      r_bus_data  <= '0;
    end else begin
      r_bus_valid <= w_pop;
      if (w_pop) begin
        r_bus_data <= r_mem[r_rd_ptr];
      end
    end
  end

  // Starvation streak and its flag; the flag is taken from the next-state
  // value so it drops in the cycle right after a Grant.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_starve_cnt <= '0;
      r_starve     <= 1'b0;
    end else begin
      r_starve_cnt <= w_starve_next;
      r_starve     <= (w_starve_next == c_st_limit);
    end
  end

  // Grants that find the FIFO empty are benign but counted, saturating at 255.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_wasted <= '0;
    end else if (w_empty_grant && (r_wasted != c_waste_max)) begin
      r_wasted <= r_wasted + 8'd1;
    end
  end

  assign full      = w_full;
  assign count     = r_count;
  assign Request   = w_request;
  assign bus_valid = r_bus_valid;
  assign bus_data  = r_bus_data;
  assign starve    = r_starve;
  assign wasted    = r_wasted;

endmodule
`default_nettype wire

// File: tb/tb_rr_requester_agent.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_requester_agent
// Purpose  : Self-checking bench for rr_requester_agent with a queue-based
//            reference model of the FIFO, bus, starvation and wasted counters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_requester_agent;

  localparam int DATA_W       = 8;
  localparam int DEPTH        = 8;
  localparam int STARVE_LIMIT = 16;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        Grant;
  logic        full;
  logic [3:0]  count;
  logic        Request;
  logic        bus_valid;
  logic [7:0]  bus_data;
  logic        starve;
  logic [7:0]  wasted;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [7:0] mq[$];
  logic       m_bv;
  logic [7:0] m_bd;
  int         m_wasted;
  int         m_streak;
  logic       m_starve;

  always #5 Clk = ~Clk;

  rr_requester_agent #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .Clk(Clk), .Reset(Reset), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .count(count), .Request(Request), .Grant(Grant),
    .bus_valid(bus_valid), .bus_data(bus_data), .starve(starve),
    .wasted(wasted)
  );

  function automatic logic exp_request();
    return (mq.size() > 1) || (mq.size() == 1 && !Grant);
  endfunction

  // Behavioural model of one clock edge, evaluated from the inputs at the edge
  task automatic model_step();
    int   sz;
    logic req;
    sz = mq.size();
    if (Reset) begin
      mq.delete();
      m_bv = 1'b0; m_bd = 8'h00; m_wasted = 0; m_streak = 0; m_starve = 1'b0;
    end else begin
      req = exp_request();
      if (Grant && sz != 0) begin
        m_bv = 1'b1;
        m_bd = mq.pop_front();
      end else begin
        m_bv = 1'b0;
      end
      if (wr_en && sz != DEPTH) mq.push_back(wr_data);
      if (Grant && sz == 0 && m_wasted < 255) m_wasted++;
      if (req && !Grant) m_streak = (m_streak < STARVE_LIMIT) ? m_streak + 1 : STARVE_LIMIT;
      else               m_streak = 0;
      m_starve = (m_streak == STARVE_LIMIT);
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic [7:0] d, input logic g);
    Reset = r; wr_en = w; wr_data = d; Grant = g;
  endtask

  task automatic tick();
    @(posedge Clk);
    model_step();
    @(negedge Clk);
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    tick();
    drive(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_vec++; if (count !== 4'd0)     begin n_err++; $display("FAIL reset_count: got %0d want 0", count); end
    n_vec++; if (Request !== 1'b0)   begin n_err++; $display("FAIL reset_request: got %b want 0", Request); end
    n_vec++; if (bus_valid !== 1'b0) begin n_err++; $display("FAIL reset_bus_valid: got %b want 0", bus_valid); end
    n_vec++; if (bus_data !== 8'h00) begin n_err++; $display("FAIL reset_bus_data: got %h want 00", bus_data); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 8'(8'h10 + i), 1'b0);
      tick();
    end
    drive(1'b0, 1'b0, 8'h00, 1'b0); #1;
    n_vec++; if (count !== 4'd3) begin n_err++; $display("FAIL preload_count: got %0d want 3", count); end
    // Reset overriding a simultaneous write and grant
    drive(1'b1, 1'b1, 8'hEE, 1'b1);
    tick();
    drive(1'b0, 1'b0, 8'h00, 1'b0); #1;
    n_vec++; if (count !== 4'd0)     begin n_err++; $display("FAIL midreset_count: got %0d want 0", count); end
    n_vec++; if (Request !== 1'b0)   begin n_err++; $display("FAIL midreset_request: got %b want 0", Request); end
    n_vec++; if (bus_valid !== 1'b0) begin n_err++; $display("FAIL midreset_bus_valid: got %b want 0", bus_valid); end
    n_vec++; if (starve !== 1'b0)    begin n_err++; $display("FAIL midreset_starve: got %b want 0", starve); end
    n_vec++; if (wasted !== 8'd0)    begin n_err++; $display("FAIL midreset_wasted: got %0d want 0", wasted); end
    n_vec++; if (full !== 1'b0)      begin n_err++; $display("FAIL midreset_full: got %b want 0", full); end
  endtask

  task automatic test_single();
    do_reset();
    drive(1'b0, 1'b1, 8'hA5, 1'b0);
    #1;
    n_vec++; if (Request !== 1'b0) begin n_err++; $display("FAIL single_req_same_cycle: got %b want 0", Request); end
    tick();
    drive(1'b0, 1'b0, 8'h00, 1'b0); #1;
    n_vec++; if (Request !== 1'b1) begin n_err++; $display("FAIL single_req_next: got %b want 1", Request); end
    drive(1'b0, 1'b0, 8'h00, 1'b1); #1;
    n_vec++; if (Request !== 1'b0) begin n_err++; $display("FAIL single_req_grant_cycle: got %b want 0", Request); end
    tick();
    drive(1'b0, 1'b0, 8'h00, 1'b0); #1;
    n_vec++; if (bus_valid !== 1'b1) begin n_err++; $display("FAIL single_bus_valid: got %b want 1", bus_valid); end
    n_vec++; if (bus_data !== 8'hA5) begin n_err++; $display("FAIL single_bus_data: got %h want a5", bus_data); end
    n_vec++; if (count !== 4'd0)     begin n_err++; $display("FAIL single_count: got %0d want 0", count); end
    tick(); #1;
    n_vec++; if (bus_valid !== 1'b0) begin n_err++; $display("FAIL single_valid_drop: got %b want 0", bus_valid); end
    n_vec++; if (bus_data !== 8'hA5) begin n_err++; $display("FAIL single_data_hold: got %h want a5", bus_data); end
  endtask

  task automatic test_fill_order();
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      drive(1'b0, 1'b1, 8'(i), 1'b0);
      tick();
    end
    drive(1'b0, 1'b0, 8'h00, 1'b0); #1;
    n_vec++; if (full !== 1'b1)  begin n_err++; $display("FAIL fill_full: got %b want 1", full); end
    n_vec++; if (count !== 4'd8) begin n_err++; $display("FAIL fill_count: got %0d want 8", count); end
    for (int i = 1; i <= 8; i++) begin
      drive(1'b0, 1'b0, 8'h00, 1'b1);
      tick(); #1;
      n_vec++; if (bus_valid !== 1'b1 || bus_data !== 8'(i))
        begin n_err++; $display("FAIL fill_order[%0d]: got v=%b d=%h want v=1 d=%h", i, bus_valid, bus_data, 8'(i)); end
      if (i == 1) begin
        n_vec++; if (full !== 1'b0) begin n_err++; $display("FAIL fill_full_clear: got %b want 0", full); end
      end
    end
    drive(1'b0, 1'b0, 8'h00, 1'b0); #1;
    n_vec++; if (count !== 4'd0) begin n_err++; $display("FAIL fill_drained: got %0d want 0", count); end
  endtask

  task automatic test_simultaneous();
    logic [7:0] exp_ord [5];
    exp_ord = '{8'h40, 8'h41, 8'h42, 8'h43, 8'h44};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 8'(8'h40 + i), 1'b0);
      tick();
    end
    drive(1'b0, 1'b1, 8'h44, 1'b1);
    tick();
    drive(1'b0, 1'b0, 8'h00, 1'b0); #1;
    n_vec++; if (count !== 4'd4)     begin n_err++; $display("FAIL simul_count: got %0d want 4", count); end
    n_vec++; if (bus_data !== exp_ord[0]) begin n_err++; $display("FAIL simul_head: got %h want 40", bus_data); end
    for (int i = 1; i < 5; i++) begin
      drive(1'b0, 1'b0, 8'h00, 1'b1);
      tick(); #1;
      n_vec++; if (bus_data !== exp_ord[i]) begin n_err++; $display("FAIL simul_order[%0d]: got %h want %h", i, bus_data, exp_ord[i]); end
    end
    // Write while full is dropped even though a pop happens in the same cycle
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 8'(8'h50 + i), 1'b0);
      tick();
    end
    drive(1'b0, 1'b1, 8'h99, 1'b1);
    tick();
    drive(1'b0, 1'b0, 8'h00, 1'b0); #1;
    n_vec++; if (count !== 4'd7) begin n_err++; $display("FAIL full_drop_count: got %0d want 7", count); end
    for (int i = 1; i < 8; i++) begin
      drive(1'b0, 1'b0, 8'h00, 1'b1);
      tick();
    end
    drive(1'b0, 1'b0, 8'h00, 1'b0); #1;
    n_vec++; if (bus_data !== 8'h57 || count !== 4'd0)
      begin n_err++; $display("FAIL full_drop_tail: got d=%h c=%0d want d=57 c=0", bus_data, count); end
  endtask

  task automatic test_empty_grant();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 8'h00, 1'b1);
      tick(); #1;
      n_vec++; if (bus_valid !== 1'b0) begin n_err++; $display("FAIL empty_bus_valid[%0d]: got %b want 0", i, bus_valid); end
    end
    drive(1'b0, 1'b0, 8'h00, 1'b0); #1;
    n_vec++; if (wasted !== 8'd3) begin n_err++; $display("FAIL empty_wasted: got %0d want 3", wasted); end
    n_vec++; if (count !== 4'd0)  begin n_err++; $display("FAIL empty_count: got %0d want 0", count); end
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 260; i++) tick();
    drive(1'b0, 1'b0, 8'h00, 1'b0); #1;
    n_vec++; if (wasted !== 8'd255) begin n_err++; $display("FAIL wasted_saturate: got %0d want 255", wasted); end
  endtask

  task automatic test_starvation();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 8'(8'h70 + i), 1'b0);
      tick(); #1;
      n_vec++; if (starve !== m_starve) begin n_err++; $display("FAIL starve_load[%0d]: got %b want %b", i, starve, m_starve); end
    end
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick(); #1;
      n_vec++; if (starve !== m_starve) begin n_err++; $display("FAIL starve_hold[%0d]: got %b want %b", i, starve, m_starve); end
    end
    n_vec++; if (starve !== 1'b1) begin n_err++; $display("FAIL starve_set: got %b want 1", starve); end
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    tick();
    drive(1'b0, 1'b0, 8'h00, 1'b0); #1;
    n_vec++; if (starve !== 1'b0) begin n_err++; $display("FAIL starve_clear: got %b want 0", starve); end
    // Streak restarts from zero: flag returns after exactly STARVE_LIMIT cycles
    for (int k = 1; k <= STARVE_LIMIT; k++) begin
      tick(); #1;
      n_vec++; if (starve !== (k == STARVE_LIMIT))
        begin n_err++; $display("FAIL starve_restart[%0d]: got %b want %b", k, starve, (k == STARVE_LIMIT)); end
    end
  endtask

  task automatic test_random();
    int gp [4];
    gp = '{50, 10, 90, 0};
    do_reset();
    for (int seg = 0; seg < 4; seg++) begin
      for (int c = 0; c < 100; c++) begin
        drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 99) < 55),
              8'($urandom), ($urandom_range(0, 99) < gp[seg]));
        #1;
        n_vec++; if (Request !== exp_request())
          begin n_err++; $display("FAIL rand_request: got %b want %b", Request, exp_request()); end
        tick(); #1;
        n_vec++; if (count !== 4'(mq.size()) || full !== (mq.size() == DEPTH))
          begin n_err++; $display("FAIL rand_count: got c=%0d f=%b want c=%0d", count, full, mq.size()); end
        n_vec++; if (bus_valid !== m_bv || bus_data !== m_bd)
          begin n_err++; $display("FAIL rand_bus: got v=%b d=%h want v=%b d=%h", bus_valid, bus_data, m_bv, m_bd); end
        n_vec++; if (starve !== m_starve || wasted !== 8'(m_wasted))
          begin n_err++; $display("FAIL rand_monitor: got s=%b w=%0d want s=%b w=%0d", starve, wasted, m_starve, m_wasted); end
      end
    end
  endtask

  initial begin
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    @(negedge Clk);
    test_reset();
    test_single();
    test_fill_order();
    test_simultaneous();
    test_empty_grant();
    test_starvation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
